// File: rtl/nanosoc_ahb_pkg.sv
// Shared AHB-Lite encodings for the nanosoc bus matrix input and output stages.
package nanosoc_ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    // HBURST encodings
    localparam logic [2:0] BUR_SINGLE = 3'b000;
    localparam logic [2:0] BUR_INCR   = 3'b001;
    localparam logic [2:0] BUR_WRAP4  = 3'b010;
    localparam logic [2:0] BUR_INCR4  = 3'b011;
    localparam logic [2:0] BUR_WRAP8  = 3'b100;
    localparam logic [2:0] BUR_INCR8  = 3'b101;
    localparam logic [2:0] BUR_WRAP16 = 3'b110;
    localparam logic [2:0] BUR_INCR16 = 3'b111;

    // HRESP encodings
    localparam logic RSP_OKAY  = 1'b0;
    localparam logic RSP_ERROR = 1'b1;

    // True for bursts with a fixed beat count (WRAPx / INCRx).
    function automatic logic burst_is_fixed(input logic [2:0] burst);
        return (burst != BUR_SINGLE) && (burst != BUR_INCR);
    endfunction

endpackage

// File: rtl/nanosoc_input_stage_hold.sv
// Slave-side input stage of the nanosoc bus matrix: forwards the master's address
// phase to the output arbiters, holding it in a register while it waits for a grant.
module nanosoc_input_stage_hold
    import nanosoc_ahb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PROT_W = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [PROT_W-1:0] HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic              HRESPS,
    output logic              sel_int,
    output logic [ADDR_W-1:0] addr_int,
    output logic [1:0]        trans_int,
    output logic              write_int,
    output logic [2:0]        size_int,
    output logic [2:0]        burst_int,
    output logic [PROT_W-1:0] prot_int,
    output logic              mastlock_int,
    input  logic              addr_in_phase,
    input  logic              data_in_phase,
    input  logic              HREADYM,
    input  logic              HRESPM,
    output logic              hold_pending
);

    logic              reg_hold_q, reg_hold_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        trans_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [2:0]        burst_q;
    logic [PROT_W-1:0] prot_q;
    logic              mastlock_q;

    logic new_tran;
    logic granted;
    logic capture;

    // Only NONSEQ/SEQ are real transfers; IDLE and BUSY are never held.
    assign new_tran = HSELS & HREADYS & HTRANSS[1];
    assign granted  = addr_in_phase & HREADYM;
    assign capture  = new_tran & ~granted & ~reg_hold_q;

    // Hold flag: set on an ungranted new transfer, cleared on the grant edge.
    always_comb begin
        reg_hold_d = reg_hold_q;
        if (capture) begin
            reg_hold_d = 1'b1;
        end else if (reg_hold_q && granted) begin
            reg_hold_d = 1'b0;
        end
    end

    // Hold register: flag plus the captured address-phase fields.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            reg_hold_q <= 1'b0;
            addr_q     <= '0;
            trans_q    <= TRN_IDLE;
            write_q    <= 1'b0;
            size_q     <= '0;
            burst_q    <= BUR_SINGLE;
            prot_q     <= '0;
            mastlock_q <= 1'b0;
        end else begin
            reg_hold_q <= reg_hold_d;
            if (capture) begin
                addr_q     <= HADDRS;
                trans_q    <= HTRANSS;
                write_q    <= HWRITES;
                size_q     <= HSIZES;
                burst_q    <= HBURSTS;
                prot_q     <= HPROTS;
                mastlock_q <= HMASTLOCKS;
            end
        end
    end

    // Forwarding mux: held fields while waiting, live master inputs otherwise.
    always_comb begin
        sel_int      = HSELS;
        addr_int     = HADDRS;
        trans_int    = HTRANSS;
        write_int    = HWRITES;
        size_int     = HSIZES;
        burst_int    = HBURSTS;
        prot_int     = HPROTS;
        mastlock_int = HMASTLOCKS;
        if (reg_hold_q) begin
            sel_int      = 1'b1;
            addr_int     = addr_q;
            trans_int    = trans_q;
            write_int    = write_q;
            size_int     = size_q;
            burst_int    = burst_q;
            prot_int     = prot_q;
            mastlock_int = mastlock_q;
            // The arbiter may have moved on since the burst started, so a held SEQ
            // restarts as NONSEQ and no longer promises a fixed beat count.
            if (trans_q == TRN_SEQ) begin
                trans_int = TRN_NONSEQ;
                if (burst_is_fixed(burst_q)) begin
                    burst_int = BUR_INCR;
                end
            end
        end
        if (!sel_int) begin
            trans_int = TRN_IDLE;
        end
    end

    // Response path back to the master.
    always_comb begin
        HREADYOUTS = ~reg_hold_q;
        HRESPS     = RSP_OKAY;
        if (data_in_phase) begin
            HREADYOUTS = HREADYM;
            HRESPS     = HRESPM;
        end
    end

    assign hold_pending = reg_hold_q;

    // A master must not start a transfer while this stage is stalling it.
    a_no_new_tran_while_held : assert property (
        @(posedge HCLK) disable iff (!HRESETn) !(reg_hold_q && new_tran)
    );

endmodule

// File: doc/nanosoc_input_stage_hold.md
Name: nanosoc_input_stage_hold

Overview:
- Slave-side input stage of the nanosoc bus matrix, one instance per master-facing port.
- Accepts AHB-Lite address phases from its master and forwards them to the output-stage arbiters through internal signals.
- When the target output port does not grant the transfer immediately, it registers the address phase and stalls the master. The held transfer is replayed once granted.
- It is the requesting counterpart of the per-slave output arbiters: it produces the request and addr/control those arbiters select between, and it returns the selected slave's HREADY/HRESP to its own master.

Parameters:
ADDR_W, 32, address width
PROT_W, 4, HPROT width

Ports:
HCLK  in  1  AHB system clock
HRESETn  in  1  reset, synchronous, active-low
HSELS  in  1  port select from master-side decoder
HADDRS  in  ADDR_W  master address
HTRANSS  in  2  master transfer type
HWRITES  in  1  master write
HSIZES  in  3  master size
HBURSTS  in  3  master burst type
HPROTS  in  PROT_W  master protection
HMASTLOCKS  in  1  master lock
HREADYS  in  1  master-side bus HREADY
HREADYOUTS  out  1  ready returned to master
HRESPS  out  1  response returned to master
sel_int  out  1  transfer request towards output stages
addr_int  out  ADDR_W  forwarded address
trans_int  out  2  forwarded HTRANS
write_int  out  1  forwarded HWRITE
size_int  out  3  forwarded HSIZE
burst_int  out  3  forwarded HBURST
prot_int  out  PROT_W  forwarded HPROT
mastlock_int  out  1  forwarded HMASTLOCK
addr_in_phase  in  1  an output stage has this port in its address phase (granted)
data_in_phase  in  1  an output stage has this port in its data phase
HREADYM  in  1  HREADY of the selected output port
HRESPM  in  1  HRESP of the selected output port
hold_pending  out  1  registered transfer is waiting for grant

Behaviour:
- One clock, HCLK. HRESETn is synchronous and active-low: all state updates on posedge HCLK; HRESETn=0 at the edge clears everything.
- Reset values: reg_hold=0, all held fields 0, reg_trans=IDLE. Resulting outputs: HREADYOUTS=1, HRESPS=OKAY, sel_int=0, trans_int=IDLE, hold_pending=0.
- New transfer (new_tran) = HSELS & HREADYS & HTRANSS[1]. BUSY and IDLE are never held.
- Capture: at the edge, if new_tran & ~(addr_in_phase & HREADYM) & ~reg_hold, then:
  - set reg_hold=1;
  - register addr, write, size, prot, mastlock, burst and trans.
- Release: if reg_hold & addr_in_phase & HREADYM, clear reg_hold at the edge (single-cycle handover, no bubble).
- Simultaneous capture and release cannot occur, because HREADYOUTS=0 while holding forces HREADYS=0.
  - If HREADYS=1 while reg_hold=1 (illegal), the new transfer is ignored and the hold is kept. Verification flags this with an assertion.
- Forwarding mux, purely combinational:
  - reg_hold=1: forward the registered fields, sel_int=1.
  - otherwise: forward the live master inputs, sel_int=HSELS.
  - trans_int = IDLE when sel_int=0.
- Burst repair on hold: a held SEQ is presented as trans_int=NONSEQ, because the output arbiter may have re-arbitrated.
  - If the held burst was fixed-length (WRAPx/INCRx), burst_int=INCR so the arbiter does not reserve beats that will not arrive.
  - A held NONSEQ is presented unchanged.
- HREADYOUTS:
  - data_in_phase=1: HREADYOUTS=HREADYM.
  - otherwise: HREADYOUTS=~reg_hold.
- HRESPS:
  - data_in_phase=1: HRESPS=HRESPM.
  - otherwise: OKAY.
  - The two-cycle ERROR response passes through unaltered.
- Latency: a transfer granted in its own address cycle adds zero cycles. A held transfer adds N wait states, where N is the number of cycles until addr_in_phase & HREADYM.
- hold_pending = reg_hold.
- Reset mid-hold: the pending transfer is dropped; the master is reset by the same HRESETn.

Decomposition:
- Shared package nanosoc_ahb_pkg holds:
  - TRN_IDLE/BUSY/NONSEQ/SEQ;
  - BUR_SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16;
  - RSP_OKAY/ERROR.
- The same package is used by the output arbiters.
- No sub-module: a single flat module with one register block and one combinational mux.

Test Plan:
- NONSEQ SINGLE, addr 0x0000_0100, addr_in_phase=1 in the same cycle -> no hold; trans_int=NONSEQ; HREADYOUTS follows HREADYM the next cycle.
- NONSEQ, addr 0x2000_0000, addr_in_phase=0 for 3 cycles then 1 -> hold_pending=1 for 3 cycles; HREADYOUTS=0 for 3 cycles; addr_int stays 0x2000_0000; hold clears on the grant edge.
- INCR4 burst, beat 2 (SEQ, addr 0x...08) not granted -> trans_int=NONSEQ, burst_int=INCR while held; addr_int=0x...08.
- Data phase returns HRESPM=ERROR with HREADYM 0 then 1 -> HRESPS=ERROR both cycles; HREADYOUTS=0 then 1.
- HRESETn=0 for one edge while hold_pending=1 -> next cycle: hold_pending=0, HREADYOUTS=1, trans_int=IDLE.
- BUSY with HSELS=1 and no grant -> no capture; trans_int=BUSY passes through; hold_pending stays 0.
